// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-side memory subsystem.
package dmem_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_TXSTAT = 4'h4;
    localparam logic [3:0] OFF_CYCLO  = 4'h8;
    localparam logic [3:0] OFF_CYCHI  = 4'hC;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

endpackage

// File: rtl/dmem_subsys_tx_fifo.sv
// Console TX byte FIFO: registered storage, sticky overflow on dropped pushes.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    input  logic                       pop,
    output logic                       valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign valid     = (count != '0);
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_subsys.sv
// Data memory subsystem: byte-masked RAM, 64-bit cycle counter and console TX FIFO behind MMIO.
module dmem_subsys #(
    parameter int unsigned RAM_WORDS = 4096,
    parameter int unsigned TX_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wmask_i,
    output logic [31:0] rdata_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        bus_err_o
);
    import dmem_pkg::*;

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CW     = $clog2(TX_DEPTH) + 1;

    region_e          region;
    logic [3:0]       off;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]      ram [RAM_WORDS];
    logic             ram_we;
    logic             tx_push;
    logic             tx_clr_ovf;
    logic             tx_full;
    logic             tx_ovf;
    logic [CW-1:0]    tx_count;
    logic [31:0]      txstat;
    logic [63:0]      cycle_cnt;
    logic [31:0]      hi_shadow;

    assign off     = {addr_i[3:2], 2'b00};
    assign ram_idx = addr_i[RAM_AW+1:2];

    always_comb begin
        region = REG_NONE;
        if (addr_i[31:RAM_AW+2] == '0) begin
            region = REG_RAM;
        end else if (addr_i[31:4] == MMIO_BASE[31:4]) begin
            region = REG_MMIO;
        end
    end

    assign ram_we     = we_i && (region == REG_RAM);
    assign tx_push    = we_i && (region == REG_MMIO) && (off == OFF_TXDATA) && wmask_i[0];
    assign tx_clr_ovf = we_i && (region == REG_MMIO) && (off == OFF_TXSTAT) && wmask_i[0]
                        && wdata_i[STAT_OVF];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (ram_we && wmask_i[b]) begin
                ram[ram_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (tx_push),
        .push_data    (wdata_i[7:0]),
        .full         (tx_full),
        .pop          (tx_ready_i),
        .valid        (tx_valid_o),
        .head_data    (tx_data_o),
        .count        (tx_count),
        .overflow     (tx_ovf),
        .clr_overflow (tx_clr_ovf)
    );

    always_comb begin
        txstat                        = '0;
        txstat[STAT_FULL]             = tx_full;
        txstat[STAT_EMPTY]            = !tx_valid_o;
        txstat[STAT_OVF]              = tx_ovf;
        txstat[STAT_CNT_LSB +: 8]     = 8'(tx_count);
    end

    // Reads sample state before this cycle's write lands, giving pre-write data on we_i && re_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o   <= '0;
            cycle_cnt <= '0;
            hi_shadow <= '0;
            bus_err_o <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if ((we_i || re_i) && (region == REG_NONE)) begin
                bus_err_o <= 1'b1;
            end
            if (re_i) begin
                case (region)
                    REG_RAM:  rdata_o <= ram[ram_idx];
                    REG_MMIO: begin
                        case (off)
                            OFF_TXSTAT: rdata_o <= txstat;
                            OFF_CYCLO: begin
                                rdata_o   <= cycle_cnt[31:0];
                                hi_shadow <= cycle_cnt[63:32];
                            end
                            OFF_CYCHI:  rdata_o <= hi_shadow;
                            default:    rdata_o <= '0;
                        endcase
                    end
                    default:  rdata_o <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_subsys.sv
// Directed self-checking bench for dmem_subsys.
module tb_dmem_subsys;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i;
    logic        we_i;
    logic        re_i;
    logic [31:0] wdata_i;
    logic [3:0]  wmask_i;
    logic [31:0] rdata_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        bus_err_o;

    int unsigned tests = 0;
    int unsigned fails = 0;

    localparam logic [31:0] TXDATA = 32'h8000_0000;
    localparam logic [31:0] TXSTAT = 32'h8000_0004;
    localparam logic [31:0] CYCLO  = 32'h8000_0008;
    localparam logic [31:0] CYCHI  = 32'h8000_000C;

    dmem_subsys #(
        .RAM_WORDS (4096),
        .TX_DEPTH  (8),
        .MMIO_BASE (32'h8000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .re_i       (re_i),
        .wdata_i    (wdata_i),
        .wmask_i    (wmask_i),
        .rdata_o    (rdata_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .bus_err_o  (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        we_i    = w;
        re_i    = r;
        addr_i  = a;
        wdata_i = d;
        wmask_i = m;
        @(posedge clk);
        #1;
        we_i    = 1'b0;
        re_i    = 1'b0;
        wmask_i = 4'b0000;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        access(1'b1, 1'b0, a, d, m);
    endtask

    task automatic rd(input logic [31:0] a);
        access(1'b0, 1'b1, a, 32'h0, 4'b0000);
    endtask

    initial begin
        rst = 1'b1; addr_i = '0; we_i = 1'b0; re_i = 1'b0;
        wdata_i = '0; wmask_i = '0; tx_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_rdata", rdata_o, 32'h0);
        check("rst_txvalid", {31'b0, tx_valid_o}, 32'h0);
        check("rst_txdata", {24'b0, tx_data_o}, 32'h0);
        check("rst_buserr", {31'b0, bus_err_o}, 32'h0);
        rd(TXSTAT);
        check("rst_txstat", rdata_o, 32'h0000_0002);

        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h10, 32'h0000_5500, 4'b0010);
        rd(32'h10);
        check("ram_bytemask", rdata_o, 32'hDEAD_55EF);
        access(1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'b1111);
        check("ram_rw_prewrite", rdata_o, 32'hDEAD_55EF);
        rd(32'h10);
        check("ram_after_rw", rdata_o, 32'h1234_5678);
        @(posedge clk); #1;
        check("rdata_hold", rdata_o, 32'h1234_5678);

        wr(TXDATA, 32'h41, 4'b0001);
        check("tx_first_valid", {31'b0, tx_valid_o}, 32'h1);
        check("tx_first_data", {24'b0, tx_data_o}, 32'h41);
        wr(TXDATA, 32'h42, 4'b0001);
        rd(TXSTAT);
        check("tx_stat_cnt2", rdata_o, 32'h0000_0200);
        check("tx_head_held", {24'b0, tx_data_o}, 32'h41);
        tx_ready_i = 1'b1;
        @(posedge clk); #1;
        check("tx_pop1_data", {24'b0, tx_data_o}, 32'h42);
        check("tx_pop1_valid", {31'b0, tx_valid_o}, 32'h1);
        @(posedge clk); #1;
        check("tx_pop2_empty", {31'b0, tx_valid_o}, 32'h0);
        tx_ready_i = 1'b0;
        rd(TXSTAT);
        check("tx_stat_empty", rdata_o, 32'h0000_0002);

        for (int i = 0; i < 9; i++) begin
            wr(TXDATA, 32'h50 + i, 4'b0001);
        end
        rd(TXSTAT);
        check("ovf_stat", rdata_o, 32'h0000_0805);
        check("ovf_head", {24'b0, tx_data_o}, 32'h50);
        wr(TXSTAT, 32'h4, 4'b0001);
        rd(TXSTAT);
        check("ovf_cleared", rdata_o, 32'h0000_0801);

        tx_ready_i = 1'b1;
        wr(TXDATA, 32'h60, 4'b0001);
        tx_ready_i = 1'b0;
        rd(TXSTAT);
        check("full_pushpop_stat", rdata_o, 32'h0000_0801);
        check("full_pushpop_head", {24'b0, tx_data_o}, 32'h51);

        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
        rd(CYCLO);
        release dut.cycle_cnt;
        check("cyclo_value", rdata_o, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd(CYCHI);
        check("cychi_shadow", rdata_o, 32'h0);
        rd(CYCLO);
        rd(CYCHI);
        check("cychi_after_wrap", rdata_o, 32'h1);
        check("no_err_yet", {31'b0, bus_err_o}, 32'h0);

        rd(32'h4000_0000);
        check("unmapped_rdata", rdata_o, 32'h0);
        check("unmapped_err", {31'b0, bus_err_o}, 32'h1);
        rd(32'h10);
        check("err_sticky", {31'b0, bus_err_o}, 32'h1);
        check("ram_after_err", rdata_o, 32'h1234_5678);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2_err", {31'b0, bus_err_o}, 32'h0);
        check("rst2_txvalid", {31'b0, tx_valid_o}, 32'h0);
        check("rst2_rdata", rdata_o, 32'h0);
        rd(TXSTAT);
        check("rst2_txstat", rdata_o, 32'h0000_0002);

        wr(32'h3FFC, 32'hA5A5_A5A5, 4'b1111);
        rd(32'h3FFC);
        check("ram_top_word", rdata_o, 32'hA5A5_A5A5);
        check("ram_top_noerr", {31'b0, bus_err_o}, 32'h0);
        wr(CYCLO, 32'hFFFF_FFFF, 4'b1111);
        check("cyc_write_noerr", {31'b0, bus_err_o}, 32'h0);
        wr(32'h8000_0010, 32'h1, 4'b1111);
        check("mmio_past_end_err", {31'b0, bus_err_o}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
